turn_input_conditioner: RTL and testbench

- Front end for the turn-signal light sequencer. Takes the raw, bouncy, asynchronous left and right switch inputs and produces clean, debounced, arbitrated L/R request levels that feed the sequencer's L and R inputs directly.
- Pairs near-simultaneous presses into a hazard request (L=R=1), so the sequencer never sees a transient single-side request.
- Locks a committed single-side turn until that side's switch is released.

---
 rtl/turn_pkg.sv | 16 +
 rtl/turn_debounce.sv | 42 ++++
 rtl/turn_input_conditioner.sv | 75 +++++++
 tb/tb_turn_input_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared definitions for the turn-signal front end and sequencer.
// State codes are fixed so the sequencer and debug tooling can decode St.
package turn_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 3'd0,
      S_PAIR    = 3'd1,
      S_LEFT    = 3'd2,
      S_RIGHT   = 3'd3,
      S_BOTH    = 3'd4,
      S_RELEASE = 3'd5
   } turn_state_e;

endpackage

// File: rtl/turn_debounce.sv
// One switch channel: 2-FF synchronizer feeding a stable-count debouncer.
// deb flips only after DEB_CYCLES consecutive cycles of sync != deb.
module turn_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic Clk,
   input  logic Rst,
   input  logic raw,
   output logic deb
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where sync matches deb clears the count, so glitches restart it.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = ~deb_q;
         else                             cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync_q <= '0;
         deb_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign deb = deb_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// Debounces both turn switches and arbitrates them into clean L/R levels,
// pairing near-simultaneous presses into a hazard request.
module turn_input_conditioner
   import turn_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int PAIR_WIN   = 3
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               L_raw,
   input  logic               R_raw,
   output logic               L,
   output logic               R,
   output logic [STATE_W-1:0] St
);

   localparam int PW = $clog2(PAIR_WIN + 1);

   logic          deb_l, deb_r;
   turn_state_e   state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;

   turn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
      .Clk(Clk), .Rst(Rst), .raw(L_raw), .deb(deb_l)
   );

   turn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
      .Clk(Clk), .Rst(Rst), .raw(R_raw), .deb(deb_r)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
      end
   end

   // In PAIR the both-high check precedes the timeout, so a second side
   // arriving on the timeout cycle still yields a hazard.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      case (state_q)
         S_IDLE: begin
            if (deb_l && deb_r) state_d = S_BOTH;
            else if (deb_l || deb_r) begin
               state_d = S_PAIR;
               pcnt_d  = '0;
            end
         end
         S_PAIR: begin
            if (deb_l && deb_r)                  state_d = S_BOTH;
            else if (!deb_l && !deb_r)           state_d = S_IDLE;
            else if (pcnt_q == PW'(PAIR_WIN - 1)) state_d = deb_l ? S_LEFT : S_RIGHT;
            else                                 pcnt_d  = pcnt_q + 1'b1;
         end
         S_LEFT:    if (!deb_l)            state_d = S_IDLE;
         S_RIGHT:   if (!deb_r)            state_d = S_IDLE;
         S_BOTH:    if (!deb_l || !deb_r)  state_d = S_RELEASE;
         S_RELEASE: if (!deb_l && !deb_r)  state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   always_comb begin
      L  = (state_q == S_LEFT)  || (state_q == S_BOTH);
      R  = (state_q == S_RIGHT) || (state_q == S_BOTH);
      St = state_q;
   end

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner at DEB_CYCLES=4, PAIR_WIN=3.
// Edge En is the n-th rising edge after the raw change is first sampled.
module tb_turn_input_conditioner;

   localparam logic [2:0] IDLE = 3'd0, PAIR = 3'd1, LEFT = 3'd2,
                          RIGHT = 3'd3, BOTH = 3'd4, RELEASE = 3'd5;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       L_raw = 1'b0, R_raw = 1'b0;
   logic       L, R;
   logic [2:0] St;

   int checks = 0;
   int errors = 0;
   int cur = -1;

   turn_input_conditioner #(.DEB_CYCLES(4), .PAIR_WIN(3)) dut (
      .Clk(Clk), .Rst(Rst), .L_raw(L_raw), .R_raw(R_raw),
      .L(L), .R(R), .St(St)
   );

   always #5 Clk = ~Clk;

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge Clk);
      #1;
      cur++;
   endtask

   task automatic wait_to(input int k);
      while (cur < k) step();
   endtask

   task automatic reset_idle();
      L_raw = 1'b0; R_raw = 1'b0; Rst = 1'b1;
      step(); step();
      Rst = 1'b0;
      cur = -1;
   endtask

   task automatic test_reset();
      L_raw = 1'b1; R_raw = 1'b1; Rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({L, R, St} !== {1'b0, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL reset_hold%0d got L=%b R=%b St=%0d want 0 0 %0d", i, L, R, St, IDLE);
         end
      end
      Rst = 1'b0;
      cur = -1;
      wait_to(5);
      checks++;
      if ({L, St} !== {1'b0, IDLE}) begin
         errors++; $display("FAIL reset_e5 got L=%b St=%0d want 0 %0d", L, St, IDLE);
      end
      wait_to(6);
      checks++;
      if (St !== BOTH) begin errors++; $display("FAIL reset_e6 got St=%0d want %0d", St, BOTH); end
      wait_to(9);
      checks++;
      if ({L, R} !== 2'b11) begin errors++; $display("FAIL reset_e9 got L=%b R=%b want 1 1", L, R); end
   endtask

   task automatic test_left_turn();
      reset_idle();
      L_raw = 1'b1;
      wait_to(5);
      checks++;
      if (St !== IDLE) begin errors++; $display("FAIL left_e5 got St=%0d want %0d", St, IDLE); end
      wait_to(6);
      checks++;
      if (St !== PAIR) begin errors++; $display("FAIL left_e6 got St=%0d want %0d", St, PAIR); end
      wait_to(8);
      checks++;
      if ({L, St} !== {1'b0, PAIR}) begin
         errors++; $display("FAIL left_e8 got L=%b St=%0d want 0 %0d", L, St, PAIR);
      end
      wait_to(9);
      checks++;
      if ({L, R, St} !== {1'b1, 1'b0, LEFT}) begin
         errors++; $display("FAIL left_e9 got L=%b R=%b St=%0d want 1 0 %0d", L, R, St, LEFT);
      end
      wait_to(19);
      L_raw = 1'b0;
      wait_to(25);
      checks++;
      if (L !== 1'b1) begin errors++; $display("FAIL left_rel_e25 got L=%b want 1", L); end
      wait_to(26);
      checks++;
      if ({L, St} !== {1'b0, IDLE}) begin
         errors++; $display("FAIL left_rel_e26 got L=%b St=%0d want 0 %0d", L, St, IDLE);
      end
   endtask

   task automatic test_bounce();
      int bad;
      reset_idle();
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         L_raw = i[1];
         step();
         if ({L, R, St} !== {1'b0, 1'b0, IDLE}) bad++;
      end
      L_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if ({L, R, St} !== {1'b0, 1'b0, IDLE}) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL bounce got %0d non-idle cycles want 0", bad); end
   endtask

   task automatic test_hazard();
      reset_idle();
      L_raw = 1'b1;
      wait_to(1);
      R_raw = 1'b1;
      wait_to(7);
      checks++;
      if (St !== PAIR) begin errors++; $display("FAIL hazard_e7 got St=%0d want %0d", St, PAIR); end
      wait_to(8);
      checks++;
      if ({L, R, St} !== {1'b1, 1'b1, BOTH}) begin
         errors++; $display("FAIL hazard_e8 got L=%b R=%b St=%0d want 1 1 %0d", L, R, St, BOTH);
      end
      wait_to(11);
      R_raw = 1'b0;
      wait_to(17);
      checks++;
      if (St !== BOTH) begin errors++; $display("FAIL hazard_e17 got St=%0d want %0d", St, BOTH); end
      wait_to(18);
      checks++;
      if ({L, R, St} !== {1'b0, 1'b0, RELEASE}) begin
         errors++; $display("FAIL hazard_e18 got L=%b R=%b St=%0d want 0 0 %0d", L, R, St, RELEASE);
      end
      wait_to(21);
      L_raw = 1'b0;
      wait_to(27);
      checks++;
      if (St !== RELEASE) begin errors++; $display("FAIL hazard_e27 got St=%0d want %0d", St, RELEASE); end
      wait_to(28);
      checks++;
      if (St !== IDLE) begin errors++; $display("FAIL hazard_e28 got St=%0d want %0d", St, IDLE); end
   endtask

   task automatic test_right_then_left();
      reset_idle();
      R_raw = 1'b1;
      wait_to(9);
      checks++;
      if ({L, R, St} !== {1'b0, 1'b1, RIGHT}) begin
         errors++; $display("FAIL right_e9 got L=%b R=%b St=%0d want 0 1 %0d", L, R, St, RIGHT);
      end
      wait_to(19);
      L_raw = 1'b1;
      wait_to(29);
      checks++;
      if ({L, R, St} !== {1'b0, 1'b1, RIGHT}) begin
         errors++; $display("FAIL right_lock_e29 got L=%b R=%b St=%0d want 0 1 %0d", L, R, St, RIGHT);
      end
      R_raw = 1'b0;
      wait_to(35);
      checks++;
      if (R !== 1'b1) begin errors++; $display("FAIL right_e35 got R=%b want 1", R); end
      wait_to(36);
      checks++;
      if ({R, St} !== {1'b0, IDLE}) begin
         errors++; $display("FAIL right_e36 got R=%b St=%0d want 0 %0d", R, St, IDLE);
      end
      wait_to(37);
      checks++;
      if (St !== PAIR) begin errors++; $display("FAIL right_e37 got St=%0d want %0d", St, PAIR); end
      wait_to(39);
      checks++;
      if (L !== 1'b0) begin errors++; $display("FAIL right_e39 got L=%b want 0", L); end
      wait_to(40);
      checks++;
      if ({L, R, St} !== {1'b1, 1'b0, LEFT}) begin
         errors++; $display("FAIL right_e40 got L=%b R=%b St=%0d want 1 0 %0d", L, R, St, LEFT);
      end
   endtask

   task automatic test_mid_reset();
      reset_idle();
      L_raw = 1'b1;
      wait_to(9);
      checks++;
      if (St !== LEFT) begin errors++; $display("FAIL midrst_e9 got St=%0d want %0d", St, LEFT); end
      wait_to(14);
      Rst = 1'b1;
      wait_to(15);
      Rst = 1'b0;
      checks++;
      if ({L, St} !== {1'b0, IDLE}) begin
         errors++; $display("FAIL midrst_e15 got L=%b St=%0d want 0 %0d", L, St, IDLE);
      end
      // Switch re-enters the synchronizer at E16, so the turn re-commits at E25.
      wait_to(24);
      checks++;
      if ({L, St} !== {1'b0, PAIR}) begin
         errors++; $display("FAIL midrst_e24 got L=%b St=%0d want 0 %0d", L, St, PAIR);
      end
      wait_to(25);
      checks++;
      if ({L, St} !== {1'b1, LEFT}) begin
         errors++; $display("FAIL midrst_e25 got L=%b St=%0d want 1 %0d", L, St, LEFT);
      end
   endtask

   task automatic test_pair_boundary();
      // Second side debounced on the timeout cycle: hazard wins.
      reset_idle();
      L_raw = 1'b1;
      wait_to(2);
      R_raw = 1'b1;
      wait_to(9);
      checks++;
      if ({L, R, St} !== {1'b1, 1'b1, BOTH}) begin
         errors++; $display("FAIL pair_tie_e9 got L=%b R=%b St=%0d want 1 1 %0d", L, R, St, BOTH);
      end
      // One cycle later: the turn commits and the late side is ignored.
      reset_idle();
      L_raw = 1'b1;
      wait_to(3);
      R_raw = 1'b1;
      wait_to(9);
      checks++;
      if ({L, R, St} !== {1'b1, 1'b0, LEFT}) begin
         errors++; $display("FAIL pair_late_e9 got L=%b R=%b St=%0d want 1 0 %0d", L, R, St, LEFT);
      end
      wait_to(15);
      checks++;
      if ({L, R, St} !== {1'b1, 1'b0, LEFT}) begin
         errors++; $display("FAIL pair_late_e15 got L=%b R=%b St=%0d want 1 0 %0d", L, R, St, LEFT);
      end
   endtask

   initial begin
      test_reset();
      test_left_turn();
      test_bounce();
      test_hazard();
      test_right_then_left();
      test_mid_reset();
      test_pair_boundary();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
